// File: rtl/operand_forward.sv
// Operand forwarding: resolves source regs against bypass stages into a one-deep output register.
// Accept-to-output latency is 1 cycle; in_ready drops while the output is blocked, a load-use hazard is pending, or a flush is active.
module operand_forward #(
    parameter int XLEN       = 32,
    parameter int NUM_PORTS  = 2,
    parameter int NUM_STAGES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_PORTS*5-1:0]      rs,
    input  logic [NUM_PORTS*XLEN-1:0]   rf_data,
    input  logic [NUM_PORTS-1:0]        sel_reg,
    input  logic [NUM_PORTS*XLEN-1:0]   other,
    input  logic [NUM_STAGES-1:0]       stg_we,
    input  logic [NUM_STAGES*5-1:0]     stg_rd,
    input  logic [NUM_STAGES-1:0]       stg_data_ok,
    input  logic [NUM_STAGES*XLEN-1:0]  stg_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_PORTS*XLEN-1:0]   reg_out,
    output logic [NUM_PORTS*XLEN-1:0]   op_out,
    output logic [15:0]                 stall_cycles
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic [1:0]                  state;
    logic [1:0]                  state_nxt;
    logic [NUM_PORTS*XLEN-1:0]   res_dat;
    logic [NUM_PORTS*XLEN-1:0]   sel_dat;
    logic [NUM_PORTS-1:0]        port_haz;
    logic                        hazard;
    logic                        out_free;
    logic                        accept;
    logic                        stall_inc;

    // Walk stages oldest to youngest so the youngest match is the last write and wins,
    // including a not-yet-ok younger match shadowing an ok older one.
    always_comb begin
        res_dat  = '0;
        port_haz = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            res_dat[p*XLEN +: XLEN] = rf_data[p*XLEN +: XLEN];
            if (rs[p*5 +: 5] == 5'd0) begin
                res_dat[p*XLEN +: XLEN] = '0;
            end else begin
                for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                    if (stg_we[s] && (stg_rd[s*5 +: 5] == rs[p*5 +: 5])) begin
                        res_dat[p*XLEN +: XLEN] = stg_data[s*XLEN +: XLEN];
                        port_haz[p]             = !stg_data_ok[s];
                    end
                end
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel_dat[p*XLEN +: XLEN] = sel_reg[p] ? res_dat[p*XLEN +: XLEN]
                                                 : other[p*XLEN +: XLEN];
        end
    end

    // A hazard blocks acceptance even when the port's operand comes from 'other'.
    assign hazard    = |port_haz;
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = rst_n && out_free && !hazard && !flush;
    assign accept    = in_valid && in_ready;
    assign stall_inc = in_valid && hazard && out_free && !flush;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else if (accept) begin
            state_nxt = ST_FULL;
        end else if (in_valid && hazard && out_free) begin
            state_nxt = ST_STALL;
        end else if (out_valid && out_ready) begin
            state_nxt = ST_EMPTY;
        end else begin
            state_nxt = out_valid ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_EMPTY;
            out_valid    <= 1'b0;
            reg_out      <= '0;
            op_out       <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                reg_out   <= res_dat;
                op_out    <= sel_dat;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (stall_inc && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_operand_forward.sv
// Directed bench for operand_forward: forwarding priority, x0, mux, load-use stall, backpressure, flush, saturation.
module tb_operand_forward;

    localparam int XLEN       = 32;
    localparam int NUM_PORTS  = 2;
    localparam int NUM_STAGES = 4;

    logic                        clk;
    logic                        rst_n;
    logic                        flush;
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_PORTS*5-1:0]      rs;
    logic [NUM_PORTS*XLEN-1:0]   rf_data;
    logic [NUM_PORTS-1:0]        sel_reg;
    logic [NUM_PORTS*XLEN-1:0]   other;
    logic [NUM_STAGES-1:0]       stg_we;
    logic [NUM_STAGES*5-1:0]     stg_rd;
    logic [NUM_STAGES-1:0]       stg_data_ok;
    logic [NUM_STAGES*XLEN-1:0]  stg_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_PORTS*XLEN-1:0]   reg_out;
    logic [NUM_PORTS*XLEN-1:0]   op_out;
    logic [15:0]                 stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    operand_forward #(.XLEN(XLEN), .NUM_PORTS(NUM_PORTS), .NUM_STAGES(NUM_STAGES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rs           (rs),
        .rf_data      (rf_data),
        .sel_reg      (sel_reg),
        .other        (other),
        .stg_we       (stg_we),
        .stg_rd       (stg_rd),
        .stg_data_ok  (stg_data_ok),
        .stg_data     (stg_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .reg_out      (reg_out),
        .op_out       (op_out),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [4:0] r, input logic [31:0] rf,
                            input logic sel, input logic [31:0] oth);
        rs[p*5 +: 5]          = r;
        rf_data[p*XLEN +: XLEN] = rf;
        sel_reg[p]            = sel;
        other[p*XLEN +: XLEN]   = oth;
    endtask

    task automatic set_stg(input int s, input logic we, input logic [4:0] rd,
                           input logic ok, input logic [31:0] dat);
        stg_we[s]               = we;
        stg_rd[s*5 +: 5]        = rd;
        stg_data_ok[s]          = ok;
        stg_data[s*XLEN +: XLEN] = dat;
    endtask

    task automatic clear_stages();
        stg_we      = '0;
        stg_rd      = '0;
        stg_data_ok = '1;
        stg_data    = '0;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rs        = '0;
        rf_data   = '0;
        sel_reg   = '0;
        other     = '0;
        clear_stages();
        set_port(0, 5'd9, 32'h99, 1'b1, 32'h0);

        // Reset with in_valid asserted
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_op_out0", op_out[0 +: 32], 32'd0);
        check("rst_stall", {16'd0, stall_cycles}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Youngest match wins over older stage
        set_port(0, 5'd5, 32'h5555, 1'b1, 32'h0);
        set_port(1, 5'd0, 32'h0, 1'b0, 32'h0);
        set_stg(0, 1'b1, 5'd5, 1'b1, 32'hAAAA0000);
        set_stg(2, 1'b1, 5'd5, 1'b1, 32'h11);
        in_valid = 1'b1;
        #1;
        check("prio_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("prio_out_valid", {31'd0, out_valid}, 32'd1);
        check("prio_op_out0", op_out[0 +: 32], 32'hAAAA0000);
        check("prio_reg_out0", reg_out[0 +: 32], 32'hAAAA0000);
        tick();
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("drain_op_hold", op_out[0 +: 32], 32'hAAAA0000);

        // x0 reads as zero even when a stage writes x0; mux picks 'other'
        clear_stages();
        set_stg(0, 1'b1, 5'd0, 1'b1, 32'hFFFF);
        set_port(0, 5'd3, 32'h333, 1'b1, 32'h77);
        set_port(1, 5'd0, 32'hDEAD, 1'b0, 32'h40);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("x0_reg_out1", reg_out[32 +: 32], 32'd0);
        check("x0_op_out1", op_out[32 +: 32], 32'h40);
        check("rf_op_out0", op_out[0 +: 32], 32'h333);

        // Hazard blocks even for a port that selects 'other'
        clear_stages();
        set_stg(1, 1'b1, 5'd7, 1'b0, 32'h0);
        set_port(0, 5'd7, 32'h0, 1'b0, 32'h1);
        set_port(1, 5'd0, 32'h0, 1'b0, 32'h0);
        #1;
        check("haz_sel0_in_ready", {31'd0, in_ready}, 32'd0);

        // Load-use: younger not-ok match shadows an ok older stage
        tick();
        set_port(0, 5'd7, 32'h7777, 1'b1, 32'h0);
        set_stg(3, 1'b1, 5'd7, 1'b1, 32'h9999);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("lu_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
            tick();
        end
        check("lu_stall_cnt", {16'd0, stall_cycles}, 32'd3);
        check("lu_out_valid_low", {31'd0, out_valid}, 32'd0);
        set_stg(1, 1'b1, 5'd7, 1'b1, 32'h1234);
        #1;
        check("lu_release", {31'd0, in_ready}, 32'd1);
        tick();
        check("lu_op_out0", op_out[0 +: 32], 32'h1234);
        check("lu_out_valid", {31'd0, out_valid}, 32'd1);

        // Backpressure: output held, a blocked hazard is not counted
        out_ready = 1'b0;
        clear_stages();
        set_stg(2, 1'b1, 5'd4, 1'b0, 32'h0);
        set_port(0, 5'd4, 32'h44, 1'b1, 32'h0);
        #1;
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_op_hold", op_out[0 +: 32], 32'h1234);
        check("bp_stall_cnt", {16'd0, stall_cycles}, 32'd3);
        clear_stages();
        #1;
        check("bp_ready_no_haz", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rf_data[0 +: 32] = 32'hA1 + i;
            #1;
            check($sformatf("b2b_in_ready_%0d", i), {31'd0, in_ready}, 32'd1);
            tick();
            check($sformatf("b2b_op_%0d", i), op_out[0 +: 32], 32'hA1 + i);
        end

        // Flush while FULL with in_valid high and a hazard pending
        flush = 1'b1;
        rf_data[0 +: 32] = 32'hB2;
        set_stg(0, 1'b1, 5'd4, 1'b0, 32'h0);
        #1;
        check("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_no_capture", op_out[0 +: 32], 32'hA3);
        check("fl_stall_cnt", {16'd0, stall_cycles}, 32'd3);
        flush = 1'b0;

        // Saturating stall counter
        repeat (10) tick();
        check("sat_mid", {16'd0, stall_cycles}, 32'd13);
        repeat (70000) tick();
        check("sat_ffff", {16'd0, stall_cycles}, 32'h0000FFFF);
        check("sat_in_ready", {31'd0, in_ready}, 32'd0);

        // Reset mid-stall discards everything
        rst_n = 1'b0;
        tick();
        check("rst2_stall", {16'd0, stall_cycles}, 32'd0);
        check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        clear_stages();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
